// File: rtl/pdm_mic_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdm_mic_frontend: mic clock generator, 1/2-channel PDM capture and boxcar |
// | decimation to saturated signed PCM. Optional macro: PDM_DC_BLOCK_EN.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pdm_mic_frontend #(
    parameter int CLK_DIV  = 32,
    parameter int DECIM    = 256,
    parameter int NUM_CH   = 1,
    parameter int OUT_W    = 16,
    parameter int DC_SHIFT = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    input  logic                    mic_data_in,
    output logic                    mic_clk_out,
    output logic                    tick_out,
    output logic [NUM_CH*OUT_W-1:0] sample_out,
    output logic                    valid_out
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int LOG_D = $clog2(DECIM);
    localparam int TAL_W = LOG_D + 1;
    localparam int SHIFT = OUT_W - LOG_D - 1;
    localparam int SH_L  = (SHIFT > 0) ? SHIFT : 0;
    localparam int SH_R  = (SHIFT < 0) ? -SHIFT : 0;
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_SAMP0 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (OUT_W - 1));

    function automatic logic [OUT_W-1:0] saturate(input logic signed [63:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    // 2*tally - DECIM rescaled so that +/-DECIM lands on full scale
    function automatic logic [OUT_W-1:0] convert(input logic [TAL_W-1:0] t);
        logic signed [63:0] s;
        s = $signed(64'(t));
        s = (s <<< 1) - 64'(DECIM);
        s = (s <<< SH_L) >>> SH_R;
        return saturate(s);
    endfunction

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_nx;
    logic             en_q;
    logic [LOG_D-1:0] win_cnt;
    logic             win_end;
    logic             valid_raw;

    // First enabled cycle restarts the period at zero
    always_comb begin
        div_nx = div_cnt + CNT_W'(1);
        if (!enable_in)
            div_nx = CNT_HALF;
        else if (!en_q || div_cnt == CNT_LAST)
            div_nx = '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt     <= '0;
            en_q        <= 1'b0;
            mic_clk_out <= 1'b0;
            tick_out    <= 1'b0;
        end else begin
            div_cnt     <= div_nx;
            en_q        <= enable_in;
            mic_clk_out <= enable_in && (div_nx < CNT_HALF);
            tick_out    <= enable_in && (div_nx == CNT_LAST);
        end
    end

    assign win_end = tick_out && enable_in && (&win_cnt);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            win_cnt   <= '0;
            valid_raw <= 1'b0;
        end else begin
            valid_raw <= win_end;
            if (!enable_in)
                win_cnt <= '0;
            else if (tick_out)
                win_cnt <= win_cnt + LOG_D'(1);
        end
    end

`ifdef PDM_DC_BLOCK_EN
    localparam int ACC_W = OUT_W + DC_SHIFT + 1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            valid_out <= 1'b0;
        else
            valid_out <= valid_raw && enable_in;
    end
`else
    assign valid_out = valid_raw;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [CNT_W-1:0] SAMP_PT = (c == 0) ? CNT_SAMP0 : CNT_LAST;

        logic [TAL_W-1:0] tally;
        logic [TAL_W-1:0] tally_nx;
        logic [OUT_W-1:0] raw;

        // Includes the bit sampled on the window-closing cycle
        assign tally_nx = tally + TAL_W'(enable_in && (div_cnt == SAMP_PT) && mic_data_in);

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                tally <= '0;
                raw   <= '0;
            end else begin
                if (!enable_in || win_end)
                    tally <= '0;
                else
                    tally <= tally_nx;
                if (win_end)
                    raw <= convert(tally_nx);
            end
        end

`ifdef PDM_DC_BLOCK_EN
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] mean;
        logic signed [ACC_W-1:0] x_ext;
        logic signed [ACC_W-1:0] diff;
        logic [OUT_W-1:0]        dc_q;

        assign mean  = acc >>> DC_SHIFT;
        assign x_ext = ACC_W'($signed(raw));
        assign diff  = x_ext - mean;

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                acc  <= '0;
                dc_q <= '0;
            end else if (!enable_in) begin
                acc <= '0;
            end else if (valid_raw) begin
                acc  <= acc + x_ext - mean;
                dc_q <= saturate(64'(diff));
            end
        end

        assign sample_out[c*OUT_W +: OUT_W] = dc_q;
`else
        assign sample_out[c*OUT_W +: OUT_W] = raw;
`endif
    end
endmodule
`default_nettype wire

// File: tb/tb_pdm_mic_frontend.sv
`default_nettype none
// Bench: two frontends (stereo 16-bit default, mono 6-bit right-shift case)
// compared every cycle against a period/window-level behavioural model.
module tb_pdm_mic_frontend;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        data_a;
    logic        data_b;
    logic        mclk_a, tick_a, valid_a;
    logic        mclk_b, tick_b, valid_b;
    logic [31:0] sample_a;
    logic [5:0]  sample_b;

    always #5 clk = ~clk;

    pdm_mic_frontend #(.CLK_DIV(32), .DECIM(256), .NUM_CH(2), .OUT_W(16), .DC_SHIFT(8)) dut_a (
        .clk_in(clk), .rst_in(rst), .enable_in(enable), .mic_data_in(data_a),
        .mic_clk_out(mclk_a), .tick_out(tick_a), .sample_out(sample_a), .valid_out(valid_a)
    );

    pdm_mic_frontend #(.CLK_DIV(4), .DECIM(64), .NUM_CH(1), .OUT_W(6), .DC_SHIFT(8)) dut_b (
        .clk_in(clk), .rst_in(rst), .enable_in(enable), .mic_data_in(data_b),
        .mic_clk_out(mclk_b), .tick_out(tick_b), .sample_out(sample_b), .valid_out(valid_b)
    );

    int checks = 0;
    int errors = 0;

    int cd [2] = '{32, 4};
    int dec[2] = '{256, 64};
    int ow [2] = '{16, 6};
    int nch[2] = '{2, 1};

    bit running  [2];
    int j        [2];
    int cnt      [2][2];
    int exp_s    [2][2];
    bit exp_valid[2];
    int win_no   [2];
    int dens     [2][2];
    bit cur_b    [2][2];

    task automatic check_val(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Fraction of ones mapped linearly onto [-2^(w-1), 2^(w-1)], floored, then clamped
    function automatic int conv(input int c, input int d, input int w);
        longint num, q, hi, lo;
        num = longint'(2 * c - d) * (longint'(1) << (w - 1));
        q   = num / d;
        if ((num % d) != 0 && num < 0) q--;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    function automatic bit pick(input int d, input int ch, input int p);
        case (win_no[d])
            0: return ch == 0;
            1: return ch == 1;
            2: return (ch == 0) ? (p % 2 == 1) : (p % 4 != 0);
            3: return 1'b1;
            4: return 1'b0;
            default: return $urandom_range(0, 99) < dens[d][ch];
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            running[d] = 1'b0;
            exp_valid[d] = 1'b0;
            j[d] = 0;
            for (int ch = 0; ch < 2; ch++) begin
                cnt[d][ch] = 0;
                exp_s[d][ch] = 0;
            end
        end
    endtask

    task automatic edge_update();
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0;
            if (!enable) begin
                running[d] = 1'b0;
                cnt[d][0] = 0;
                cnt[d][1] = 0;
            end else if (!running[d]) begin
                running[d] = 1'b1;
                j[d] = 0;
                cnt[d][0] = 0;
                cnt[d][1] = 0;
            end else begin
                if (j[d] % cd[d] == cd[d] - 1 && (j[d] / cd[d]) % dec[d] == dec[d] - 1) begin
                    exp_valid[d] = 1'b1;
                    for (int ch = 0; ch < nch[d]; ch++) exp_s[d][ch] = conv(cnt[d][ch], dec[d], ow[d]);
                    cnt[d][0] = 0;
                    cnt[d][1] = 0;
                    win_no[d]++;
                end
                j[d]++;
            end
        end
    endtask

    task automatic check_and_drive();
        bit ob_m, ob_t, ob_v, dv;
        int os[2];
        int ph, p;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                ob_m = mclk_a; ob_t = tick_a; ob_v = valid_a;
                os[0] = int'($signed(sample_a[15:0]));
                os[1] = int'($signed(sample_a[31:16]));
            end else begin
                ob_m = mclk_b; ob_t = tick_b; ob_v = valid_b;
                os[0] = int'($signed(sample_b));
                os[1] = 0;
            end
            ph = running[d] ? j[d] % cd[d] : 0;
            p  = running[d] ? j[d] / cd[d] : 0;
            check_val($sformatf("mic_clk%0d", d), int'(ob_m), int'(running[d] && ph < cd[d] / 2));
            check_val($sformatf("tick%0d", d), int'(ob_t), int'(running[d] && ph == cd[d] - 1));
            check_val($sformatf("valid%0d", d), int'(ob_v), int'(exp_valid[d]));
            for (int ch = 0; ch < nch[d]; ch++)
                check_val($sformatf("sample%0d_ch%0d", d, ch), os[ch], exp_s[d][ch]);
            if (running[d]) begin
                if (ph == 0) begin
                    if (p % dec[d] == 0)
                        for (int ch = 0; ch < 2; ch++) dens[d][ch] = $urandom_range(0, 100);
                    for (int ch = 0; ch < 2; ch++) cur_b[d][ch] = pick(d, ch, p % dec[d]);
                    cnt[d][0] += int'(cur_b[d][0]);
                    if (nch[d] == 2) cnt[d][1] += int'(cur_b[d][1]);
                end
                dv = (ph < cd[d] / 2) ? cur_b[d][0] : cur_b[d][1];
            end else begin
                dv = 1'($urandom_range(0, 1));
            end
            if (d == 0) data_a = dv;
            else        data_b = dv;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     edge_update();
        @(negedge clk);
        check_and_drive();
    endtask

    initial begin
        int guard;
        int nv;
        rst = 1'b1;
        enable = 1'b0;
        data_a = 1'b0;
        data_b = 1'b0;
        for (int d = 0; d < 2; d++) win_no[d] = 0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        enable = 1'b1;

        // Fixed-pattern windows for the stereo unit, random ones after that
        repeat (4 * 8192 + 10) step();

        guard = 0;
        while (!(running[0] && j[0] % 32 == 0 && (j[0] / 32) % 256 == 120) && guard < 20000) begin
            step();
            guard++;
        end
        check_val("reach_period_120", int'(guard < 20000), 1);

        enable = 1'b0;
        nv = 0;
        repeat (100) begin
            step();
            nv += int'(valid_a);
        end
        enable = 1'b1;
        repeat (8192) begin
            step();
            nv += int'(valid_a);
        end
        check_val("no_valid_partial_window", nv, 0);
        step();
        check_val("valid_after_256_periods", int'(valid_a), 1);

        repeat (3000) step();
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_mic_clk_a", int'(mclk_a), 0);
        check_val("async_rst_tick_a", int'(tick_a), 0);
        check_val("async_rst_valid_a", int'(valid_a), 0);
        check_val("async_rst_sample_a", int'(sample_a), 0);
        check_val("async_rst_mic_clk_b", int'(mclk_b), 0);
        check_val("async_rst_sample_b", int'(sample_b), 0);
        #1 rst = 1'b0;
        model_reset();
        repeat (8192 + 100) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
